// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO, BUF_SIZE x DATA_WIDTH, registered read data,
//             full/empty flags decoded from (ADDR_SIZE+1)-bit pointers.
//             Optional occupancy output enabled by macro FIFO_COUNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int BUF_SIZE   = 8,
  parameter int ADDR_SIZE  = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] data_w,
  output logic                  full,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] data_r,
  output logic                  empty
`ifdef FIFO_COUNT_EN
  ,
  output logic [ADDR_SIZE:0]    count
`endif
);

  localparam logic [ADDR_SIZE:0] PTR_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

  // Extra MSB on each pointer separates "same slot, same lap" (empty)
  // from "same slot, one lap apart" (full).
  logic [ADDR_SIZE:0]    wptr;
  logic [ADDR_SIZE:0]    rptr;
  logic [DATA_WIDTH-1:0] mem [BUF_SIZE];
  logic                  wr_ok;
  logic                  rd_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_SIZE] != rptr[ADDR_SIZE]) &&
                 (wptr[ADDR_SIZE-1:0] == rptr[ADDR_SIZE-1:0]);

  // Both requests are qualified by the flags as they stand before the edge,
  // so a write into an empty FIFO never falls through to the read side.
  assign wr_ok = wen & ~full;
  assign rd_ok = ren & ~empty;

`ifdef FIFO_COUNT_EN
  // Modulo subtraction of the extended pointers yields 0..BUF_SIZE directly.
  assign count = wptr - rptr;
`endif

  // Write pointer advances on every accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
    end else if (wr_ok) begin
      wptr <= wptr + PTR_ONE;
    end
  end

  // Storage array is deliberately left out of reset; the pointers alone
  // define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr[ADDR_SIZE-1:0]] <= data_w;
    end
  end

  // Read pointer and registered read data; data_r holds when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr   <= '0;
      data_r <= '0;
    end else if (rd_ok) begin
      rptr   <= rptr + PTR_ONE;
      data_r <= mem[rptr[ADDR_SIZE-1:0]];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo
//  Brief    : Self-checking bench for sync_fifo; queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  localparam int BUF_SIZE   = 8;
  localparam int ADDR_SIZE  = 3;
  localparam int DATA_WIDTH = 32;

  logic                  clk;
  logic                  rst_n;
  logic                  wen;
  logic [DATA_WIDTH-1:0] data_w;
  logic                  full;
  logic                  ren;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  empty;
`ifdef FIFO_COUNT_EN
  logic [ADDR_SIZE:0]    count;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: queue contents and expected registered read data.
  logic [DATA_WIDTH-1:0] sb [$];
  logic [DATA_WIDTH-1:0] exp_r;
  int                    wr_accepts;

  sync_fifo #(
    .BUF_SIZE  (BUF_SIZE),
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (wen),
    .data_w(data_w),
    .full  (full),
    .ren   (ren),
    .data_r(data_r),
    .empty (empty)
`ifdef FIFO_COUNT_EN
    ,
    .count (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle at the negedge, update the model from start-of-cycle
  // occupancy, then return at the next negedge ready for sampling.
  task automatic drive_cycle(input logic w, input logic [DATA_WIDTH-1:0] d, input logic r);
    bit rd_ok;
    bit wr_ok;
    wen    = w;
    data_w = d;
    ren    = r;
    rd_ok  = r && (sb.size() > 0);
    wr_ok  = w && (sb.size() < BUF_SIZE);
    if (rd_ok) exp_r = sb.pop_front();
    if (wr_ok) begin
      sb.push_back(d);
      wr_accepts++;
    end
    @(posedge clk);
    @(negedge clk);
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    wen    = 1'b0;
    ren    = 1'b0;
    data_w = '0;
    #1;
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    total++;
    if (data_r !== 32'h0) begin bad++; $display("FAIL reset_data_r: got %h want 0", data_r); end
`ifdef FIFO_COUNT_EN
    total++;
    if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
`endif
    sb.delete();
    exp_r = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < BUF_SIZE; i++) begin
      drive_cycle(1'b1, 32'h11111111 * (i + 1), 1'b0);
      total++;
      if (full !== (i == BUF_SIZE - 1)) begin
        bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == BUF_SIZE - 1));
      end
      total++;
      if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty[%0d]: got %b want 0", i, empty); end
    end
    drive_cycle(1'b1, 32'hDEADBEEF, 1'b0);
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL overflow_full: got %b want 1", full); end
`ifdef FIFO_COUNT_EN
    total++;
    if (count !== 4'd8) begin bad++; $display("FAIL overflow_count: got %0d want 8", count); end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < BUF_SIZE; i++) begin
      drive_cycle(1'b0, '0, 1'b1);
      total++;
      if (data_r !== 32'h11111111 * (i + 1)) begin
        bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_r, 32'h11111111 * (i + 1));
      end
      total++;
      if (empty !== (i == BUF_SIZE - 1)) begin
        bad++; $display("FAIL drain_empty[%0d]: got %b want %b", i, empty, (i == BUF_SIZE - 1));
      end
    end
    drive_cycle(1'b0, '0, 1'b1);
    total++;
    if (data_r !== 32'h88888888) begin bad++; $display("FAIL underflow_data: got %h want 88888888", data_r); end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL underflow_empty: got %b want 1", empty); end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < BUF_SIZE; i++) drive_cycle(1'b1, 32'h00001000 + i, 1'b0);
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL sfull_pre: got %b want 1", full); end
    drive_cycle(1'b1, 32'hCAFEF00D, 1'b1);
    total++;
    if (data_r !== 32'h00001000) begin bad++; $display("FAIL sfull_data: got %h want 00001000", data_r); end
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL sfull_full: got %b want 0", full); end
    // Remaining seven entries come out in order and the dropped write never appears.
    for (int i = 1; i < BUF_SIZE; i++) begin
      drive_cycle(1'b0, '0, 1'b1);
      total++;
      if (data_r !== 32'h00001000 + i) begin
        bad++; $display("FAIL sfull_drain[%0d]: got %h want %h", i, data_r, 32'h00001000 + i);
      end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL sfull_empty_after: got %b want 1", empty); end
  endtask

  task automatic test_simul_empty();
    drive_cycle(1'b1, 32'hA5A5A5A5, 1'b1);
    total++;
    if (data_r !== 32'h00001007) begin bad++; $display("FAIL sempty_hold: got %h want 00001007", data_r); end
    total++;
    if (empty !== 1'b0) begin bad++; $display("FAIL sempty_empty: got %b want 0", empty); end
    drive_cycle(1'b0, '0, 1'b1);
    total++;
    if (data_r !== 32'hA5A5A5A5) begin bad++; $display("FAIL sempty_read: got %h want a5a5a5a5", data_r); end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL sempty_after: got %b want 1", empty); end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 32'h01020304, 1'b0);
    drive_cycle(1'b1, 32'h05060708, 1'b0);
    drive_cycle(1'b1, 32'h090A0B0C, 1'b1);
    // Assert reset between edges; flags and data_r must clear without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL midrst_empty: got %b want 1", empty); end
    total++;
    if (data_r !== 32'h0) begin bad++; $display("FAIL midrst_data: got %h want 0", data_r); end
    sb.delete();
    exp_r = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int start_wr;
    start_wr = wr_accepts;
    for (int c = 0; c < 1000; c++) begin
      drive_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      total++;
      if (data_r !== exp_r) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", c, data_r, exp_r); end
      total++;
      if (full !== (sb.size() == BUF_SIZE)) begin
        bad++; $display("FAIL rand_full[%0d]: got %b want %b", c, full, (sb.size() == BUF_SIZE));
      end
      total++;
      if (empty !== (sb.size() == 0)) begin
        bad++; $display("FAIL rand_empty[%0d]: got %b want %b", c, empty, (sb.size() == 0));
      end
`ifdef FIFO_COUNT_EN
      total++;
      if (int'(count) !== sb.size()) begin
        bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, count, sb.size());
      end
`endif
    end
    // At least three full passes through the buffer must have been exercised.
    total++;
    if ((wr_accepts - start_wr) < 3 * BUF_SIZE) begin
      bad++; $display("FAIL rand_wrap: got %0d writes want >= %0d", wr_accepts - start_wr, 3 * BUF_SIZE);
    end
  endtask

  initial begin
    wr_accepts = 0;
    test_reset();
    test_fill();
    test_drain();
    test_simul_full();
    test_simul_empty();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
